// File: rtl/enemy_bullet_ctl.sv
// Per-enemy bullet controller: spawns one bullet at the enemy muzzle, moves it down each tick, retires it on exit or hit.
// Optional ENEMY_BULLET_AIM_EN: the bullet's x steers one pixel per tick toward player_x.
module enemy_bullet_ctl #(
  parameter int N          = 1,
  parameter int TICK_LIMIT = 500000,
  parameter int SPEED      = 4,
  parameter int X_OFFSET   = 20,
  parameter int Y_OFFSET   = 40,
  parameter int Y_LIMIT    = 600,
  parameter int COOL_TICKS = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        shot_in,
  input  logic        hit_in,
  input  logic [11:0] player_x,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        bullet_on,
  output logic        fired
);

  localparam int TW = 20;
  localparam int CW = (COOL_TICKS < 2) ? 1 : $clog2(COOL_TICKS);

  if (N < 0 || TICK_LIMIT < 2 || TICK_LIMIT > (1 << 20) || COOL_TICKS < 1) begin : g_param_check
    $error("enemy_bullet_ctl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [CW-1:0]   cool_cnt;
  logic            tick;
  logic [12:0]     x_sum;
  logic [12:0]     y_sum;
  logic [12:0]     y_step;
  logic [11:0]     x_spawn;
  logic [11:0]     y_spawn;

  assign tick = (tick_cnt == TW'(TICK_LIMIT - 1));

  // Muzzle position saturates at the 12-bit screen edge instead of wrapping.
  assign x_sum   = {1'b0, xpos_in} + 13'(X_OFFSET);
  assign y_sum   = {1'b0, ypos_in} + 13'(Y_OFFSET);
  assign x_spawn = x_sum[12] ? 12'hFFF : x_sum[11:0];
  assign y_spawn = y_sum[12] ? 12'hFFF : y_sum[11:0];
  assign y_step  = {1'b0, ypos_out} + 13'(SPEED);

`ifndef ENEMY_BULLET_AIM_EN
  logic unused_player;
  assign unused_player = ^player_x;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      cool_cnt  <= '0;
      xpos_out  <= '0;
      ypos_out  <= '0;
      bullet_on <= 1'b0;
      fired     <= 1'b0;
    end else begin
      // Free-running; phase is never disturbed by state changes.
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      fired    <= 1'b0;
      case (state)
        IDLE: begin
          if (shot_in) begin
            state     <= FLY;
            xpos_out  <= x_spawn;
            ypos_out  <= y_spawn;
            bullet_on <= 1'b1;
            fired     <= 1'b1;
          end
        end
        FLY: begin
          if (hit_in) begin
            state     <= COOL;
            cool_cnt  <= '0;
            bullet_on <= 1'b0;
          end else if (tick) begin
            if (y_step >= 13'(Y_LIMIT)) begin
              state     <= COOL;
              cool_cnt  <= '0;
              bullet_on <= 1'b0;
            end else begin
              ypos_out <= y_step[11:0];
`ifdef ENEMY_BULLET_AIM_EN
              // Strict compares keep x inside 0..4095 without explicit clamps.
              if (xpos_out < player_x) begin
                xpos_out <= xpos_out + 12'd1;
              end else if (xpos_out > player_x) begin
                xpos_out <= xpos_out - 12'd1;
              end
`endif
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cool_cnt == CW'(COOL_TICKS - 1)) begin
              state <= IDLE;
            end else begin
              cool_cnt <= cool_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bullet_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_bullet_ctl.sv
// Bench for enemy_bullet_ctl: directed vector table, hand sequences for corner cases, randomized run vs. a behavioural model.
// Honours ENEMY_BULLET_AIM_EN when the design is built with it.
module tb_enemy_bullet_ctl;
  localparam int TL = 4;
  localparam int SP = 4;
  localparam int XO = 20;
  localparam int YO = 40;
  localparam int YL = 600;
  localparam int CT = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in, ypos_in, player_x;
  logic        shot_in, hit_in;
  logic [11:0] xpos_out, ypos_out;
  logic        bullet_on, fired;

  always #5 pclk = ~pclk;

  enemy_bullet_ctl #(
    .N(1), .TICK_LIMIT(TL), .SPEED(SP), .X_OFFSET(XO), .Y_OFFSET(YO),
    .Y_LIMIT(YL), .COOL_TICKS(CT)
  ) dut (
    .pclk(pclk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .shot_in(shot_in), .hit_in(hit_in), .player_x(player_x),
    .xpos_out(xpos_out), .ypos_out(ypos_out), .bullet_on(bullet_on), .fired(fired)
  );

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];

  // Behavioural model: a bullet is either flying, cooling for some ticks, or absent.
  int m_cnt, m_x, m_y, m_cool;
  bit m_on, m_fired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat12(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_x = 0; m_y = 0; m_cool = 0; m_on = 0; m_fired = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit tk;
    tk = (m_cnt == TL - 1);
    m_cnt = (m_cnt + 1) % TL;
    m_fired = 0;
    if (m_on) begin
      if (hit_in) begin
        m_on = 0; m_cool = CT;
      end else if (tk) begin
        if (m_y + SP >= YL) begin
          m_on = 0; m_cool = CT;
        end else begin
          m_y = m_y + SP;
`ifdef ENEMY_BULLET_AIM_EN
          if (m_x < int'(player_x)) m_x = m_x + 1;
          else if (m_x > int'(player_x)) m_x = m_x - 1;
`endif
        end
      end
    end else if (m_cool > 0) begin
      if (tk) m_cool = m_cool - 1;
    end else if (shot_in) begin
      m_on = 1; m_fired = 1;
      m_x = sat12(int'(xpos_in) + XO);
      m_y = sat12(int'(ypos_in) + YO);
    end
    exp_q.push_back({12'(m_x), 12'(m_y), m_on, m_fired});
  endtask

  // One clock: model advances on the edge, outputs compared 1 ns later.
  task automatic step();
    logic [25:0] e;
    @(posedge pclk);
    model_edge();
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb_xpos", xpos_out, e[25:14]);
      check("sb_ypos", ypos_out, e[13:2]);
      check("sb_on", bullet_on, e[1]);
      check("sb_fired", fired, e[0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; shot_in = 0; hit_in = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          shot;
    bit          hit;
    logic [11:0] ex;
    logic [11:0] ey;
    bit          eon;
    bit          efired;
  } vec_t;

  function automatic vec_t mk(bit s, bit h, int ex, int ey, bit on, bit f);
    vec_t v;
    v.shot = s; v.hit = h; v.ex = 12'(ex); v.ey = 12'(ey); v.eon = on; v.efired = f;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          done;
    int          n;
    logic [11:0] prev_y;
    int          aim_exp[3];

    xpos_in = 12'd100; ypos_in = 12'd70; player_x = 12'd120;
    shot_in = 0; hit_in = 0; rst = 1'b1;
    #1;
    check("reset_xpos", xpos_out, 0);
    check("reset_ypos", ypos_out, 0);
    check("reset_on", bullet_on, 0);
    check("reset_fired", fired, 0);

    // Ticks fall on edges 4, 8, 12, 16 after reset release.
    tbl[0]  = mk(0, 0,   0,   0, 0, 0);
    tbl[1]  = mk(1, 0, 120, 110, 1, 1);
    tbl[2]  = mk(0, 0, 120, 110, 1, 0);
    tbl[3]  = mk(1, 0, 120, 114, 1, 0);
    tbl[4]  = mk(0, 0, 120, 114, 1, 0);
    tbl[5]  = mk(0, 0, 120, 114, 1, 0);
    tbl[6]  = mk(0, 0, 120, 114, 1, 0);
    tbl[7]  = mk(0, 0, 120, 118, 1, 0);
    tbl[8]  = mk(0, 1, 120, 118, 0, 0);
    for (int i = 9; i < 16; i++) tbl[i] = mk(1, 0, 120, 118, 0, 0);
    tbl[16] = mk(1, 0, 120, 110, 1, 1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      shot_in = tbl[i].shot; hit_in = tbl[i].hit;
      step();
      check($sformatf("vec%0d_xpos", i), xpos_out, tbl[i].ex);
      check($sformatf("vec%0d_ypos", i), ypos_out, tbl[i].ey);
      check($sformatf("vec%0d_on", i), bullet_on, tbl[i].eon);
      check($sformatf("vec%0d_fired", i), fired, tbl[i].efired);
    end

    // Free flight from y=110 until the bullet leaves the field.
    shot_in = 0; hit_in = 0; done = 0; prev_y = ypos_out;
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      if (bullet_on) prev_y = ypos_out;
      else done = 1;
    end
    check("flight_done", done, 1);
    check("flight_last_y", prev_y, 598);
    check("flight_hold_y", ypos_out, 598);

    // Hit coincident with a tick at y=200, then re-fire with shot held.
    shot_in = 1; ypos_in = 12'd160; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (fired) done = 1;
    end
    check("spawn200_done", done, 1);
    check("spawn200_y", ypos_out, 200);
    for (int i = 0; i < TL && m_cnt != TL - 1; i++) step();
    hit_in = 1;
    step();
    hit_in = 0;
    check("hit_on", bullet_on, 0);
    check("hit_y", ypos_out, 200);
    n = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      n++;
      if (fired) done = 1;
    end
    check("refire_done", done, 1);
    check("refire_latency", n, 9);

    // Asynchronous reset between clock edges while flying.
    shot_in = 0;
    step(); step();
    #3 rst = 1'b1;
    #1;
    check("arst_xpos", xpos_out, 0);
    check("arst_ypos", ypos_out, 0);
    check("arst_on", bullet_on, 0);
    check("arst_fired", fired, 0);
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    xpos_in = 12'd100; ypos_in = 12'd70; shot_in = 1;
    step();
    shot_in = 0;
    check("post_rst_xpos", xpos_out, 120);
    check("post_rst_ypos", ypos_out, 110);
    check("post_rst_on", bullet_on, 1);
    check("post_rst_fired", fired, 1);
    step();
    check("post_rst_fired_pulse", fired, 0);

    // Saturating spawn retires on the first tick.
    do_reset();
    xpos_in = 12'd4090; ypos_in = 12'd4090; shot_in = 1;
    step();
    shot_in = 0;
    check("sat_xpos", xpos_out, 4095);
    check("sat_ypos", ypos_out, 4095);
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      n++;
      if (!bullet_on) done = 1;
    end
    check("sat_retire_done", done, 1);
    check("sat_retire_steps", n, 3);
    check("sat_hold_y", ypos_out, 4095);

    // Aim steering toward player_x=118.
`ifdef ENEMY_BULLET_AIM_EN
    aim_exp[0] = 119; aim_exp[1] = 118; aim_exp[2] = 118;
`else
    aim_exp[0] = 120; aim_exp[1] = 120; aim_exp[2] = 120;
`endif
    do_reset();
    player_x = 12'd118; xpos_in = 12'd100; ypos_in = 12'd70; shot_in = 1;
    step();
    shot_in = 0;
    check("aim_spawn_x", xpos_out, 120);
    repeat (3) step();
    check("aim_x0", xpos_out, aim_exp[0]);
    repeat (4) step();
    check("aim_x1", xpos_out, aim_exp[1]);
    repeat (4) step();
    check("aim_x2", xpos_out, aim_exp[2]);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      shot_in  = ($urandom_range(0, 1) == 1);
      hit_in   = ($urandom_range(0, 39) == 0);
      xpos_in  = 12'($urandom_range(0, 4095));
      ypos_in  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 4095))
                                             : 12'($urandom_range(400, 599));
      player_x = 12'($urandom_range(0, 4095));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
